// File: rtl/task_op_pkg.sv
// Shared definitions for the task operation bus: opcodes, field widths and the
// op-word packing helper used by the dispatcher and the task modules.
package task_op_pkg;

    localparam int ID_W   = 4;
    localparam int OPC_W  = 4;
    localparam int ARG_W  = 4;
    localparam int CMD_W  = ID_W + OPC_W + ARG_W;
    localparam int WORD_W = 16;

    localparam logic [ID_W-1:0] ID_NONE = 4'h0;

    localparam logic [OPC_W-1:0] OP_READY    = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUSPEND  = 4'h2;
    localparam logic [OPC_W-1:0] OP_WAIT     = 4'h3;
    localparam logic [OPC_W-1:0] OP_KILL     = 4'h4;
    localparam logic [OPC_W-1:0] OP_SET_PRIO = 4'h5;
    localparam logic [OPC_W-1:0] OP_SET_HIT  = 4'h6;
    localparam logic [OPC_W-1:0] OP_EXECUTE  = 4'h7;
    localparam logic [OPC_W-1:0] OP_FINISH   = 4'hF;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [OPC_W-1:0] opcode;
        logic [ARG_W-1:0] arg;
    } cmd_t;

    typedef enum logic {
        ST_IDLE,
        ST_EXEC
    } disp_state_t;

    function automatic logic [WORD_W-1:0] pack_op(input logic [ID_W-1:0]  id,
                                                  input logic [OPC_W-1:0] opcode,
                                                  input logic [ARG_W-1:0] arg);
        return {4'h0, id, opcode, arg};
    endfunction

    // Opcodes that take a task off the CPU and therefore end its slice early.
    function automatic logic is_abort_op(input logic [OPC_W-1:0] opcode);
        return (opcode == OP_KILL) || (opcode == OP_SUSPEND) || (opcode == OP_WAIT);
    endfunction

endpackage

// File: rtl/task_cmd_fifo.sv
// Synchronous FIFO for queued host commands; read data is the current head
// entry, valid whenever empty is low.
module task_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          pop_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // A full queue refuses the push even when a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are meaningful, so clearing the array buys nothing.
    always_ff @(posedge CLK) begin
        if (do_push && !RST) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/task_op_dispatcher.sv
// Issuing side of the task operation bus: serializes queued host commands and
// runs time slices for the sorter winner with Execute / Finish-execution words.
module task_op_dispatcher
    import task_op_pkg::*;
#(
    parameter int SLICE_CYCLES = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ID_W-1:0]   cmd_id,
    input  logic [OPC_W-1:0]  cmd_opcode,
    input  logic [ARG_W-1:0]  cmd_arg,
    input  logic [7:0]        in_winner,
    output logic [WORD_W-1:0] out_op,
    output logic              exec_busy,
    output logic [ID_W-1:0]   exec_id
);

    localparam int                CNT_W    = $clog2(SLICE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SLICE_CYCLES - 1);

    disp_state_t         state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [ID_W-1:0]     exec_id_q, exec_id_nxt;
    logic [WORD_W-1:0]   out_op_q, out_op_nxt;

    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CMD_W-1:0]    fifo_rd_data;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    cmd_t                head;
    logic [ID_W-1:0]     winner_id;
    logic                abort_hit;
    logic                unused_ok;

    task_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (cmd_valid),
        .push_data ({cmd_id, cmd_opcode, cmd_arg}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head      = cmd_t'(fifo_rd_data);
    assign winner_id = in_winner[7:4];
    assign cmd_ready = !fifo_full;
    assign unused_ok = ^{in_winner[3:0], fifo_count};

    // The abort is judged on the word already on the bus, so it lands one
    // cycle after that word appears.
    assign abort_hit = (state == ST_EXEC) &&
                       (out_op_q[11:8] == exec_id_q) &&
                       is_abort_op(out_op_q[7:4]);

    // NOTE: every output of this block gets a default first so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        exec_id_nxt = exec_id_q;
        out_op_nxt  = '0;
        fifo_pop    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head.id != ID_NONE)
                        out_op_nxt = pack_op(head.id, head.opcode, head.arg);
                end else if (winner_id != ID_NONE) begin
                    out_op_nxt  = pack_op(winner_id, OP_EXECUTE, 4'h0);
                    exec_id_nxt = winner_id;
                    cnt_nxt     = CNT_LOAD;
                    state_nxt   = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (abort_hit) begin
                    exec_id_nxt = ID_NONE;
                    state_nxt   = ST_IDLE;
                end else if (cnt == '0) begin
                    out_op_nxt  = pack_op(exec_id_q, OP_FINISH, 4'h0);
                    exec_id_nxt = ID_NONE;
                    state_nxt   = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        if (head.id != ID_NONE)
                            out_op_nxt = pack_op(head.id, head.opcode, head.arg);
                    end
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            exec_id_q <= ID_NONE;
            out_op_q  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            exec_id_q <= exec_id_nxt;
            out_op_q  <= out_op_nxt;
        end
    end

    assign out_op    = out_op_q;
    assign exec_busy = (state == ST_EXEC);
    assign exec_id   = exec_id_q;

endmodule
